pipa_responder: RTL and testbench
=================================

Name: pipa_responder

Overview:
- Accelerometer-side (PIPA) responder for the AGC's PIPA interrogation interface on the DE0-Nano build.
- The AGC drives PIPASW (interval strobe) and PIPDAT (data-sample pulse). This block answers on PIPAXp/PIPAXm, PIPAYp/PIPAYm and PIPAZp/PIPAZm using pulse-rebalanced moding over 6-interval frames.
- Per-axis acceleration commands set each frame to 3-3 (net 0), 4-2 (net +2) or 2-4 (net -2).
- Replaces fixed 3-3 spoofing so flight software sees controllable delta-V.

Parameters:
- ACC_W, 8, width of signed per-axis acceleration command (pulses per frame, two's complement).
- SUM_W, 16, width of signed per-axis residual accumulator.
- FRAME_LEN, 6, PIPASW intervals per moding frame (even, >= 4).

Ports:
- SIM_CLK  input  1  system clock (51.2 MHz); all state updates on rising edge.
- SIM_RST_n  input  1  synchronous active-low reset.
- ENABLE  input  1  1 = respond; 0 = all PIPA outputs forced 0, frame state frozen.
- PIPASW  input  1  AGC interval strobe, asynchronous to SIM_CLK semantics; rising edge = new interval.
- PIPDAT  input  1  AGC data pulse; gated combinationally onto the selected output.
- ACCX, ACCY, ACCZ  input  ACC_W each  signed commanded pulses per frame per axis.
- PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm  output  1 each  PIPA pulse responses.
- SLOT  output  3  current interval index within frame, 0..FRAME_LEN-1.
- FRAME_DONE  output  1  one-cycle pulse when a frame boundary is taken.

Behaviour:
- Reset (SIM_RST_n=0 at clock edge):
  - SLOT=0, FRAME_DONE=0.
  - All accumulators=0, all axis modes=3-3.
  - PIPASW synchroniser flops=0, edge detector armed.
  - All PIPA outputs 0 while reset asserted.
  - Reset mid-frame discards the partial frame; no pulse emitted the cycle after reset deassertion unless PIPDAT and ENABLE are high.
- PIPASW sync: 2-flop synchroniser plus edge detect.
  - Rising edge detected 3 SIM_CLK cycles after the input edge.
  - Edges closer than 3 clocks are merged into one event.
- On a detected edge with ENABLE=1:
  - If SLOT=FRAME_LEN-1: SLOT<=0, FRAME_DONE=1 for one cycle, per-axis mode update (below).
  - Otherwise SLOT<=SLOT+1.
- Per-axis mode update at each frame boundary:
  - acc_next = sat(acc + sext(ACCn)), saturating at SUM_W signed limits.
  - If acc_next >= 2: mode=4-2, acc<=acc_next-2.
  - Else if acc_next <= -2: mode=2-4, acc<=acc_next+2.
  - Else: mode=3-3, acc<=acc_next.
  - ACCn is sampled only on the boundary cycle; changes elsewhere are ignored.
- Slot selection within a frame (h=FRAME_LEN/2):
  - 3-3: plus in slots 0..h-1, minus otherwise.
  - 4-2: plus in slots 0..h, minus otherwise.
  - 2-4: plus in slots 0..h-2, minus otherwise.
- Output rule:
  - Exactly one of each axis pair is selected at any time; the select is registered.
  - Output = PIPDAT & ENABLE & select & SIM_RST_n. This is the only combinational path.
- The new frame's modes take effect in the same cycle SLOT returns to 0.
- ENABLE=0: edges ignored, SLOT and accumulators hold. Resuming continues from the held SLOT.
- Simultaneous PIPASW edge and reset: reset wins.
- Simultaneous PIPDAT and slot change: the output uses the select register value after that clock edge.
- Saturated accumulator: no wrap. Sustained |ACC| > 2 keeps the axis in 4-2 or 2-4 indefinitely.

Test Plan:
- ACC*=0, 12 PIPASW edges with a PIPDAT pulse per interval -> each axis: 3 plus then 3 minus per frame, net 0; FRAME_DONE twice.
- ACCX=+2, ACCY=-2, ACCZ=+1, 4 frames -> X emits 4p/2m every frame after the first boundary. Y emits 2p/4m. Z alternates 3-3 and 4-2, net +4 over the 4 frames.
- Reset asserted at SLOT=4 with ACCX=+2 -> SLOT=0, accumulators 0, outputs 0. The next frame runs 3-3 until the first boundary.
- ENABLE low for 3 PIPASW edges mid-frame at SLOT=2 -> SLOT stays 2, no PIPA pulses. On re-enable the next edge gives SLOT=3.
- ACCX=+127 for 600 frames with SUM_W=16 -> accumulator saturates at 32767 with no wrap; X stays in 4-2.
- Two PIPASW rising edges 2 clocks apart -> SLOT advances by exactly 1.

Source files
------------

// File: rtl/pipa_responder.sv
// PIPA responder: answers AGC PIPA interrogations with pulse-rebalanced
// 3-3 / 4-2 / 2-4 moding per axis over FRAME_LEN-interval frames.

module pipa_axis #(
  parameter int ACC_W     = 8,
  parameter int SUM_W     = 16,
  parameter int FRAME_LEN = 6
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             boundary,
  input  logic [2:0]       slot_nxt,
  input  logic [ACC_W-1:0] acc_cmd,
  output logic             sel_q
);
  typedef enum logic [1:0] {MODE_33, MODE_42, MODE_24} mode_e;

  localparam logic signed [SUM_W:0]   SAT_MAX = $signed({2'b00, {(SUM_W-1){1'b1}}});
  localparam logic signed [SUM_W:0]   SAT_MIN = $signed({2'b11, {(SUM_W-1){1'b0}}});
  localparam logic signed [SUM_W-1:0] TWO     = SUM_W'(2);
  localparam logic signed [SUM_W-1:0] NTWO    = -TWO;
  localparam logic [2:0] H    = 3'(FRAME_LEN / 2);
  localparam logic [2:0] H_P1 = 3'(FRAME_LEN / 2 + 1);
  localparam logic [2:0] H_M1 = 3'(FRAME_LEN / 2 - 1);

  logic signed [SUM_W-1:0] acc_q, acc_d, acc_sat;
  logic signed [SUM_W:0]   sum_wide;
  mode_e                   mode_q, mode_d;
  logic                    sel_d;

  always_comb begin
    sum_wide = {{(SUM_W+1-ACC_W){acc_cmd[ACC_W-1]}}, acc_cmd} + {acc_q[SUM_W-1], acc_q};
    if (sum_wide > SAT_MAX)      acc_sat = SAT_MAX[SUM_W-1:0];
    else if (sum_wide < SAT_MIN) acc_sat = SAT_MIN[SUM_W-1:0];
    else                         acc_sat = sum_wide[SUM_W-1:0];

    acc_d  = acc_q;
    mode_d = mode_q;
    if (boundary) begin
      if (acc_sat >= TWO) begin
        mode_d = MODE_42;
        acc_d  = acc_sat - TWO;
      end else if (acc_sat <= NTWO) begin
        mode_d = MODE_24;
        acc_d  = acc_sat + TWO;
      end else begin
        mode_d = MODE_33;
        acc_d  = acc_sat;
      end
    end

    // Select follows the next slot/mode so it lines up with SLOT after the edge.
    case (mode_d)
      MODE_42: sel_d = slot_nxt < H_P1;
      MODE_24: sel_d = slot_nxt < H_M1;
      default: sel_d = slot_nxt < H;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      acc_q  <= '0;
      mode_q <= MODE_33;
      sel_q  <= 1'b1;
    end else begin
      acc_q  <= acc_d;
      mode_q <= mode_d;
      sel_q  <= sel_d;
    end
  end
endmodule

module pipa_responder #(
  parameter int ACC_W     = 8,
  parameter int SUM_W     = 16,
  parameter int FRAME_LEN = 6
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST_n,
  input  logic             ENABLE,
  input  logic             PIPASW,
  input  logic             PIPDAT,
  input  logic [ACC_W-1:0] ACCX,
  input  logic [ACC_W-1:0] ACCY,
  input  logic [ACC_W-1:0] ACCZ,
  output logic             PIPAXp,
  output logic             PIPAXm,
  output logic             PIPAYp,
  output logic             PIPAYm,
  output logic             PIPAZp,
  output logic             PIPAZm,
  output logic [2:0]       SLOT,
  output logic             FRAME_DONE
);
  localparam int         NUM_LANES = 3;
  localparam logic [2:0] LAST      = 3'(FRAME_LEN - 1);

  logic [2:0] sw_pipe_q, sw_pipe_d;
  logic [1:0] hold_q, hold_d;
  logic [2:0] slot_q, slot_d;
  logic       frame_done_q, frame_done_d;
  logic       raw_edge, edge_ok, step, boundary;

  logic [NUM_LANES-1:0][ACC_W-1:0] acc_cmd;
  logic [NUM_LANES-1:0]            sel;
  logic                            gate;

  assign acc_cmd = {ACCZ, ACCY, ACCX};

  always_comb begin
    sw_pipe_d = {sw_pipe_q[1:0], PIPASW};
    raw_edge  = sw_pipe_q[1] & ~sw_pipe_q[2];
    // Holdoff swallows a second edge arriving within 3 clocks of the first.
    edge_ok   = raw_edge && (hold_q == 2'd0);
    hold_d    = hold_q;
    if (edge_ok)              hold_d = 2'd2;
    else if (hold_q != 2'd0)  hold_d = hold_q - 2'd1;

    step         = edge_ok & ENABLE;
    boundary     = step && (slot_q == LAST);
    frame_done_d = boundary;
    slot_d       = slot_q;
    if (boundary)  slot_d = 3'd0;
    else if (step) slot_d = slot_q + 3'd1;
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_n) begin
      sw_pipe_q    <= '0;
      hold_q       <= '0;
      slot_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      sw_pipe_q    <= sw_pipe_d;
      hold_q       <= hold_d;
      slot_q       <= slot_d;
      frame_done_q <= frame_done_d;
    end
  end

  for (genvar a = 0; a < NUM_LANES; a++) begin : g_axis
    pipa_axis #(.ACC_W(ACC_W), .SUM_W(SUM_W), .FRAME_LEN(FRAME_LEN)) u_axis (
      .gclk     (SIM_CLK),
      .grst_n   (SIM_RST_n),
      .boundary (boundary),
      .slot_nxt (slot_d),
      .acc_cmd  (acc_cmd[a]),
      .sel_q    (sel[a])
    );
  end

  assign gate   = PIPDAT & ENABLE & SIM_RST_n;
  assign PIPAXp = gate &  sel[0];
  assign PIPAXm = gate & ~sel[0];
  assign PIPAYp = gate &  sel[1];
  assign PIPAYm = gate & ~sel[1];
  assign PIPAZp = gate &  sel[2];
  assign PIPAZm = gate & ~sel[2];

  assign SLOT       = slot_q;
  assign FRAME_DONE = frame_done_q;
endmodule

// File: tb/tb_pipa_responder.sv
// Scoreboard bench for pipa_responder: frame-level reference model pushes the
// expected PIPA response per data pulse; a negedge monitor pops and compares.

module tb_pipa_responder;
  localparam int FL = 6;
  localparam int H  = FL / 2;
  localparam int SMAX = 32767;
  localparam int SMIN = -32768;

  typedef struct packed {
    logic [5:0] pipa;   // {Zm,Zp,Ym,Yp,Xm,Xp}
    logic [2:0] slot;
  } exp_t;

  logic       SIM_CLK = 1'b0;
  logic       SIM_RST_n, ENABLE, PIPASW, PIPDAT;
  logic [7:0] ACCX, ACCY, ACCZ;
  logic       PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm;
  logic [2:0] SLOT;
  logic       FRAME_DONE;

  pipa_responder #(.ACC_W(8), .SUM_W(16), .FRAME_LEN(FL)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST_n(SIM_RST_n), .ENABLE(ENABLE),
    .PIPASW(PIPASW), .PIPDAT(PIPDAT),
    .ACCX(ACCX), .ACCY(ACCY), .ACCZ(ACCZ),
    .PIPAXp(PIPAXp), .PIPAXm(PIPAXm), .PIPAYp(PIPAYp), .PIPAYm(PIPAYm),
    .PIPAZp(PIPAZp), .PIPAZm(PIPAZm), .SLOT(SLOT), .FRAME_DONE(FRAME_DONE)
  );

  always #10 SIM_CLK = ~SIM_CLK;

  int   n_chk = 0, n_pass = 0;
  int   fd_seen = 0;
  exp_t q[$];

  // Reference model: frame-level residual and per-frame net pulse offset.
  int slot_m, frames_m;
  int acc_m[3];
  int net_m[3];   // +1 = 4-2, 0 = 3-3, -1 = 2-4

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    slot_m = 0;
    for (int a = 0; a < 3; a++) begin acc_m[a] = 0; net_m[a] = 0; end
  endtask

  task automatic model_step();
    int cmd[3];
    int s;
    if (!ENABLE) return;
    if (slot_m != FL - 1) begin slot_m++; return; end
    slot_m = 0;
    frames_m++;
    cmd[0] = int'($signed(ACCX)); cmd[1] = int'($signed(ACCY)); cmd[2] = int'($signed(ACCZ));
    for (int a = 0; a < 3; a++) begin
      s = acc_m[a] + cmd[a];
      if (s > SMAX) s = SMAX;
      if (s < SMIN) s = SMIN;
      if (s >= 2)       begin net_m[a] = 1;  acc_m[a] = s - 2; end
      else if (s <= -2) begin net_m[a] = -1; acc_m[a] = s + 2; end
      else              begin net_m[a] = 0;  acc_m[a] = s;     end
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.slot = 3'(slot_m);
    e.pipa = '0;
    for (int a = 0; a < 3; a++)
      if (ENABLE && SIM_RST_n) begin
        // plus for the first H+net slots of the frame, minus for the rest
        if (slot_m < H + net_m[a]) e.pipa[2*a]   = 1'b1;
        else                       e.pipa[2*a+1] = 1'b1;
      end
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge SIM_CLK); #1; end
  endtask

  task automatic pulse();
    q.push_back(model_exp());
    PIPDAT = 1'b1;
    tick(1);
    PIPDAT = 1'b0;
  endtask

  task automatic interval(input bit dat);
    PIPASW = 1'b1; tick(4);
    PIPASW = 1'b0; tick(3);
    model_step();
    if (dat) pulse();
  endtask

  always @(negedge SIM_CLK) begin
    exp_t e;
    if (FRAME_DONE) fd_seen++;
    if (PIPDAT) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard: data pulse with empty queue at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("pipa", int'({PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp}), int'(e.pipa));
        chk("slot", int'(SLOT), int'(e.slot));
      end
    end
  end

  initial begin
    int v;
    SIM_RST_n = 1'b0; ENABLE = 1'b1; PIPASW = 1'b0; PIPDAT = 1'b0;
    ACCX = '0; ACCY = '0; ACCZ = '0;
    frames_m = 0;
    model_reset();
    tick(2);
    pulse();                       // reset state: outputs forced 0, SLOT 0
    chk("frame_done_rst", int'(FRAME_DONE), 0);
    SIM_RST_n = 1'b1;
    tick(2);
    pulse();                       // slot 0, 3-3 -> plus on every axis

    // zero command: 2 frames of 3-3
    for (int i = 0; i < 2 * FL; i++) interval(1'b1);

    // +2 / -2 / +1 for 4 frames
    ACCX = 8'd2; ACCY = 8'hFE; ACCZ = 8'd1;
    for (int i = 0; i < 4 * FL; i++) interval(1'b1);

    // drive to SLOT=4 then reset mid-frame
    while (slot_m != 4) interval(1'b1);
    SIM_RST_n = 1'b0;
    tick(1);
    model_reset();
    pulse();
    SIM_RST_n = 1'b1;
    tick(1);
    for (int i = 0; i < 2 * FL; i++) interval(1'b1);

    // ENABLE low for 3 edges at SLOT=2
    while (slot_m != 2) interval(1'b1);
    ENABLE = 1'b0;
    for (int i = 0; i < 3; i++) interval(1'b1);
    ENABLE = 1'b1;
    interval(1'b1);                // expects SLOT 3

    // two rising edges 2 clocks apart merge into one step
    PIPASW = 1'b1; tick(1);
    PIPASW = 1'b0; tick(1);
    PIPASW = 1'b1; tick(4);
    PIPASW = 1'b0; tick(3);
    model_step();
    pulse();

    // randomized commands and data-pulse presence
    for (int f = 0; f < 12; f++) begin
      v = int'($urandom_range(10)) - 5; ACCX = 8'(v);
      v = int'($urandom_range(10)) - 5; ACCY = 8'(v);
      v = int'($urandom_range(10)) - 5; ACCZ = 8'(v);
      for (int i = 0; i < FL; i++) interval($urandom_range(3) != 0);
    end

    // saturation: sustained extreme commands, 600 frames
    ACCX = 8'd127; ACCY = 8'h80; ACCZ = 8'd0;
    for (int i = 0; i < 600 * FL; i++) interval(i % 2 == 0);
    chk("sat_x_mode", net_m[0], 1);
    chk("sat_y_mode", net_m[1], -1);

    tick(3);
    chk("frame_done_count", fd_seen, frames_m);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
